// File: rtl/bus_data_memory.sv
// Word-addressed data memory behind a request/ready bus with a fixed, programmable
// number of wait states. Out-of-range and read+write-collision accesses complete with err.
module bus_data_memory #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned DEPTH       = 256,
   parameter int          WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              m_read,
   input  logic              m_write,
   output logic [DATA_W-1:0] rdata,
   output logic              ready,
   output logic              err,
   output logic              busy
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned AW1   = ADDR_W + 1;
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Parameter sanity, caught at elaboration
   if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
      $error("bus_data_memory: WAIT_STATES must be in 0..15");
   end
   if (DEPTH < 1 || 64'(DEPTH) > (64'(1) << ADDR_W)) begin : g_bad_depth
      $error("bus_data_memory: DEPTH must be in 1..2**ADDR_W");
   end

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                rd_q, rd_d;
   logic                wr_q, wr_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                ready_q, ready_d;
   logic                err_q, err_d;

   logic                in_range_c;
   logic                complete_c;
   logic                mem_we_c;
   logic                mem_re_c;
   logic [IDX_W-1:0]    idx_c;

   logic [DATA_W-1:0]   mem [DEPTH];

   // Range check is done one bit wider so DEPTH == 2**ADDR_W needs no special case
   assign in_range_c = ({1'b0, addr_q} < AW1'(DEPTH));
   assign complete_c = (state_q == S_WAIT) && (cnt_q == '0);
   assign mem_we_c   = complete_c && wr_q && !rd_q && in_range_c;
   assign mem_re_c   = complete_c && rd_q && !wr_q && in_range_c;
   assign idx_c      = IDX_W'(addr_q);

   // Next-state and output logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      rdata_d = rdata_q;
      ready_d = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (m_read || m_write) begin
               state_d = S_WAIT;
               cnt_d   = CNT_W'(WAIT_STATES);
               addr_d  = addr;
               wdata_d = wdata;
               rd_d    = m_read;
               wr_d    = m_write;
            end
         end
         S_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d = S_IDLE;
               ready_d = 1'b1;
               err_d   = (rd_q && wr_q) || !in_range_c;
               if (mem_re_c) begin
                  rdata_d = mem[idx_c];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control and output registers; an async reset mid-access drops it silently
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         err_q   <= err_d;
      end
   end

   // Storage array is intentionally not reset
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         mem[idx_c] <= wdata_q;
      end
   end

   assign rdata = rdata_q;
   assign ready = ready_q;
   assign err   = err_q;
   assign busy  = (state_q == S_WAIT);

endmodule

// File: tb/tb_bus_data_memory.sv
// Directed bench for bus_data_memory: three instances cover default, zero-wait/short-depth,
// and wide/three-wait configurations.
module tb_bus_data_memory;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   int n_tests = 0;
   int n_fail  = 0;

   // Instance A: defaults (8/8/256, 1 wait state)
   logic [7:0] a_addr, a_wd, a_rdata;
   logic       a_rd, a_wr, a_rdy, a_err, a_busy;
   // Instance B: DEPTH=200, 0 wait states
   logic [7:0] b_addr, b_wd, b_rdata;
   logic       b_rd, b_wr, b_rdy, b_err, b_busy;
   // Instance C: 16-bit data, 10-bit address, 1024 words, 3 wait states
   logic [9:0]  c_addr;
   logic [15:0] c_wd, c_rdata;
   logic        c_rd, c_wr, c_rdy, c_err, c_busy;

   bus_data_memory u_a (
      .clk(clk), .rst_n(rst_n), .addr(a_addr), .wdata(a_wd), .m_read(a_rd), .m_write(a_wr),
      .rdata(a_rdata), .ready(a_rdy), .err(a_err), .busy(a_busy));

   bus_data_memory #(.DEPTH(200), .WAIT_STATES(0)) u_b (
      .clk(clk), .rst_n(rst_n), .addr(b_addr), .wdata(b_wd), .m_read(b_rd), .m_write(b_wr),
      .rdata(b_rdata), .ready(b_rdy), .err(b_err), .busy(b_busy));

   bus_data_memory #(.DATA_W(16), .ADDR_W(10), .DEPTH(1024), .WAIT_STATES(3)) u_c (
      .clk(clk), .rst_n(rst_n), .addr(c_addr), .wdata(c_wd), .m_read(c_rd), .m_write(c_wr),
      .rdata(c_rdata), .ready(c_rdy), .err(c_err), .busy(c_busy));

   int          sel = 0;
   logic        o_rdy, o_err, o_busy;
   logic [15:0] o_rdata;

   always_comb begin
      o_rdy = 1'b0; o_err = 1'b0; o_busy = 1'b0; o_rdata = '0;
      case (sel)
         0: begin o_rdy = a_rdy; o_err = a_err; o_busy = a_busy; o_rdata = {8'h00, a_rdata}; end
         1: begin o_rdy = b_rdy; o_err = b_err; o_busy = b_busy; o_rdata = {8'h00, b_rdata}; end
         default: begin o_rdy = c_rdy; o_err = c_err; o_busy = c_busy; o_rdata = c_rdata; end
      endcase
   end

   task automatic drive(input int s, input logic rd, input logic wr,
                        input logic [9:0] ad, input logic [15:0] wd);
      case (s)
         0: begin a_rd = rd; a_wr = wr; a_addr = ad[7:0]; a_wd = wd[7:0]; end
         1: begin b_rd = rd; b_wr = wr; b_addr = ad[7:0]; b_wd = wd[7:0]; end
         default: begin c_rd = rd; c_wr = wr; c_addr = ad; c_wd = wd; end
      endcase
   endtask

   // One request pulse; returns edges from acceptance to ready (99 on timeout)
   task automatic access(input int s, input logic rd, input logic wr,
                         input logic [9:0] ad, input logic [15:0] wd,
                         output int lat, output logic [15:0] rdat, output logic e);
      sel = s;
      @(negedge clk); drive(s, rd, wr, ad, wd);
      @(posedge clk);
      @(negedge clk); drive(s, 1'b0, 1'b0, ad, wd);
      lat = 99; rdat = '0; e = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (o_rdy) begin lat = k; rdat = o_rdata; e = o_err; break; end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      a_rd = 1'b1; a_wr = 1'b0; a_addr = 8'h10; a_wd = '0;
      b_rd = 1'b0; b_wr = 1'b1; b_addr = '0; b_wd = '0;
      c_rd = 1'b0; c_wr = 1'b0; c_addr = '0; c_wd = '0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({a_rdy, a_err, a_busy, b_rdy, b_err, b_busy, c_rdy, c_err, c_busy} !== 9'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl got %b exp 0", {a_rdy, a_err, a_busy, b_rdy, b_err, b_busy, c_rdy, c_err, c_busy});
      end
      n_tests++;
      if ({a_rdata, b_rdata, c_rdata} !== 32'h0) begin
         n_fail++; $display("FAIL reset_rdata got %h exp 0", {a_rdata, b_rdata, c_rdata});
      end
      @(negedge clk);
      rst_n = 1'b1; a_rd = 1'b0; b_wr = 1'b0;
   endtask

   task automatic test_write_read();
      int lat; logic [15:0] rd; logic e;
      access(0, 1'b0, 1'b1, 10'h10, 16'h00A5, lat, rd, e);
      n_tests++;
      if (lat !== 2 || e !== 1'b0) begin
         n_fail++; $display("FAIL s1_write got lat=%0d err=%b exp lat=2 err=0", lat, e);
      end
      access(0, 1'b1, 1'b0, 10'h10, 16'h0000, lat, rd, e);
      n_tests++;
      if (lat !== 2 || e !== 1'b0 || rd !== 16'h00A5) begin
         n_fail++; $display("FAIL s1_read got lat=%0d err=%b rdata=%h exp 2 0 00a5", lat, e, rd);
      end
   endtask

   task automatic test_rw_conflict();
      int lat; logic [15:0] rd; logic e;
      access(0, 1'b0, 1'b1, 10'h05, 16'h005A, lat, rd, e);
      access(0, 1'b1, 1'b1, 10'h05, 16'h00FF, lat, rd, e);
      n_tests++;
      if (lat !== 2 || e !== 1'b1) begin
         n_fail++; $display("FAIL s4_conflict got lat=%0d err=%b exp lat=2 err=1", lat, e);
      end
      n_tests++;
      if (rd !== 16'h00A5) begin
         n_fail++; $display("FAIL s4_rdata_kept got %h exp 00a5", rd);
      end
      access(0, 1'b1, 1'b0, 10'h05, 16'h0000, lat, rd, e);
      n_tests++;
      if (rd !== 16'h005A || e !== 1'b0) begin
         n_fail++; $display("FAIL s4_mem_kept got rdata=%h err=%b exp 005a 0", rd, e);
      end
   endtask

   task automatic test_back_to_back();
      int lat; logic [15:0] rd; logic e;
      int h0, h1; logic [15:0] v0, v1; int hits; int extra;
      access(1, 1'b0, 1'b1, 10'h01, 16'h0011, lat, rd, e);
      n_tests++;
      if (lat !== 1) begin
         n_fail++; $display("FAIL s2_ws0_latency got %0d exp 1", lat);
      end
      access(1, 1'b0, 1'b1, 10'h02, 16'h0022, lat, rd, e);
      sel = 1; h0 = 99; h1 = 99; v0 = '0; v1 = '0; hits = 0; extra = 0;
      @(negedge clk); b_rd = 1'b1; b_addr = 8'h01;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (b_rdy) begin
            if (hits == 0) begin h0 = k; v0 = o_rdata; b_addr = 8'h02; end
            else if (hits == 1) begin h1 = k; v1 = o_rdata; b_rd = 1'b0; end
            else extra++;
            hits++;
         end
      end
      n_tests++;
      if (h0 !== 1 || h1 !== 3 || extra !== 0) begin
         n_fail++; $display("FAIL s2_ready_edges got %0d,%0d extra=%0d exp 1,3 extra=0", h0, h1, extra);
      end
      n_tests++;
      if (v0 !== 16'h0011 || v1 !== 16'h0022) begin
         n_fail++; $display("FAIL s2_rdata got %h,%h exp 0011,0022", v0, v1);
      end
   endtask

   task automatic test_range();
      int lat; logic [15:0] rd; logic e;
      access(1, 1'b0, 1'b1, 10'h00, 16'h005C, lat, rd, e);
      access(1, 1'b1, 1'b0, 10'h00, 16'h0000, lat, rd, e);
      access(1, 1'b0, 1'b1, 10'hC8, 16'h003C, lat, rd, e);
      n_tests++;
      if (lat !== 1 || e !== 1'b1 || rd !== 16'h005C) begin
         n_fail++; $display("FAIL s3_oob_write got lat=%0d err=%b rdata=%h exp 1 1 005c", lat, e, rd);
      end
      access(1, 1'b1, 1'b0, 10'h00, 16'h0000, lat, rd, e);
      n_tests++;
      if (e !== 1'b0 || rd !== 16'h005C) begin
         n_fail++; $display("FAIL s3_no_wrap got err=%b rdata=%h exp 0 005c", e, rd);
      end
      access(1, 1'b0, 1'b1, 10'hC7, 16'h0099, lat, rd, e);
      access(1, 1'b1, 1'b0, 10'hC7, 16'h0000, lat, rd, e);
      n_tests++;
      if (e !== 1'b0 || rd !== 16'h0099) begin
         n_fail++; $display("FAIL s3_last_word got err=%b rdata=%h exp 0 0099", e, rd);
      end
      access(1, 1'b1, 1'b0, 10'hC8, 16'h0000, lat, rd, e);
      n_tests++;
      if (e !== 1'b1 || rd !== 16'h0099) begin
         n_fail++; $display("FAIL s3_oob_read got err=%b rdata=%h exp 1 0099", e, rd);
      end
   endtask

   task automatic test_wide();
      int lat; logic [15:0] rd; logic e;
      access(2, 1'b0, 1'b1, 10'h3FF, 16'hBEEF, lat, rd, e);
      n_tests++;
      if (lat !== 4 || e !== 1'b0) begin
         n_fail++; $display("FAIL s6_write got lat=%0d err=%b exp 4 0", lat, e);
      end
      access(2, 1'b1, 1'b0, 10'h3FF, 16'h0000, lat, rd, e);
      n_tests++;
      if (rd !== 16'hBEEF || e !== 1'b0) begin
         n_fail++; $display("FAIL s6_read got rdata=%h err=%b exp beef 0", rd, e);
      end
   endtask

   task automatic test_reset_abort();
      int lat; logic [15:0] rd; logic e; logic seen;
      access(2, 1'b0, 1'b1, 10'h20, 16'h1234, lat, rd, e);
      access(2, 1'b1, 1'b0, 10'h20, 16'h0000, lat, rd, e);
      sel = 2;
      @(negedge clk); drive(2, 1'b0, 1'b1, 10'h20, 16'h0077);
      @(posedge clk);
      @(negedge clk); drive(2, 1'b0, 1'b0, 10'h20, 16'h0077);
      @(posedge clk);
      @(posedge clk);
      #2; rst_n = 1'b0; #1;
      n_tests++;
      if ({c_rdy, c_err, c_busy} !== 3'b0 || c_rdata !== 16'h0000) begin
         n_fail++; $display("FAIL s5_async_reset got ctrl=%b rdata=%h exp 000 0000", {c_rdy, c_err, c_busy}, c_rdata);
      end
      seen = 1'b0;
      repeat (3) begin @(posedge clk); #1; seen = seen | c_rdy; end
      n_tests++;
      if (seen !== 1'b0) begin
         n_fail++; $display("FAIL s5_no_ready got %b exp 0", seen);
      end
      @(negedge clk); rst_n = 1'b1; drive(2, 1'b1, 1'b0, 10'h20, 16'h0000);
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (c_busy !== 1'b1) begin
         n_fail++; $display("FAIL s5_first_edge_accept got busy=%b exp 1", c_busy);
      end
      drive(2, 1'b0, 1'b0, 10'h20, 16'h0000);
      lat = 99; rd = '0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (c_rdy) begin lat = k; rd = c_rdata; break; end
      end
      n_tests++;
      if (lat !== 4 || rd !== 16'h1234) begin
         n_fail++; $display("FAIL s5_mem_kept got lat=%0d rdata=%h exp 4 1234", lat, rd);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_rw_conflict();
      test_back_to_back();
      test_range();
      test_wide();
      test_reset_abort();
      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
